tile_draw_scheduler: RTL and testbench

Sequences LCD tile redraws for the snake playfield. It scans the 16x12 grid one cell per cycle, encodes the object flags supplied for the current cell, and compares the result against a shadow copy of what is on screen. On any mismatch it issues one draw command to the LCD command engine and waits for `cmd_done`. It sits between the object-lookup logic, which answers for the current (x,y), and the display command engine.

---
 rtl/tile_draw_scheduler_if.sv | 35 +++
 rtl/tile_draw_scheduler.sv | 158 +++++++++++++++
 tb/tb_tile_draw_scheduler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_draw_scheduler_if.sv
// Bundles the lookup-side and command-engine-side signals of the tile draw scheduler.
// Latency: n/a (wiring only).
// Backpressure: draw_req is held until a cmd_done pulse completes the command.
interface tile_draw_scheduler_if;
  // Object flags for the cell currently presented on (x, y)
  logic       snakeHead;
  logic       snakeBody;
  logic       apple;
  logic       border;
  logic       GameOver;
  // Command engine handshake
  logic       cmd_done;
  logic       draw_req;
  logic [3:0] draw_x;
  logic [3:0] draw_y;
  logic [2:0] draw_code;
  // Scan position and status
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       init_cycle;
  logic       frame_done;

  // Scheduler side
  modport master (
    input  snakeHead, snakeBody, apple, border, GameOver, cmd_done,
    output x, y, obj_code, draw_req, draw_x, draw_y, draw_code, init_cycle, frame_done
  );

  // Lookup logic / command engine side
  modport slave (
    output snakeHead, snakeBody, apple, border, GameOver, cmd_done,
    input  x, y, obj_code, draw_req, draw_x, draw_y, draw_code, init_cycle, frame_done
  );
endinterface

// File: rtl/tile_draw_scheduler.sv
// Scans the playfield one cell per cycle and issues a draw for every cell whose code differs from the on-screen shadow.
// Latency: draw_req rises the edge after the mismatching SCAN cycle; an unchanged cell costs one cycle.
// Backpressure: scanning stalls in WAIT with the command held stable until cmd_done.
module tile_draw_scheduler #(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 12,
  parameter int FRAME_GAP = 0
) (
  input  logic              clk,
  input  logic              nrst,
  tile_draw_scheduler_if.master bus
);

  localparam int CELLS   = GRID_W * GRID_H;
  localparam int AW      = $clog2(CELLS);
  // The gap state always lasts at least one cycle so frame_done has a home.
  localparam int GAP_LEN = (FRAME_GAP > 0) ? FRAME_GAP : 1;
  localparam int GW      = $clog2(GAP_LEN) + 1;

  typedef enum logic [1:0] {S_RESET, S_SCAN, S_WAIT, S_GAP} state_t;

  state_t         state, state_nxt;
  logic [3:0]     x_q, y_q;
  logic [3:0]     dx_q, dy_q;
  logic [2:0]     dcode_q;
  logic           force_q;
  logic           pending_q;
  logic           go_q;
  logic [GW-1:0]  gap_cnt;
  logic [2:0]     shadow [CELLS];

  logic [2:0]     obj_code;
  logic [2:0]     shadow_rd;
  logic [AW-1:0]  rd_idx;
  logic [AW-1:0]  wr_idx;
  logic           last_cell;
  logic           need_draw;
  logic           gap_done;
  logic           advance;
  logic           enter_gap;
  logic           go_rise;

  assign rd_idx    = AW'(32'(y_q) * 32'(GRID_W) + 32'(x_q));
  assign wr_idx    = AW'(32'(dy_q) * 32'(GRID_W) + 32'(dx_q));
  assign shadow_rd = shadow[rd_idx];
  assign last_cell = (x_q == 4'(GRID_W - 1)) && (y_q == 4'(GRID_H - 1));
  assign need_draw = force_q || (obj_code != shadow_rd);
  assign gap_done  = (gap_cnt == GW'(GAP_LEN - 1));
  assign advance   = ((state == S_SCAN) && !need_draw) || ((state == S_WAIT) && bus.cmd_done);
  assign enter_gap = (state != S_GAP) && (state_nxt == S_GAP);
  assign go_rise   = bus.GameOver && !go_q;

  // Priority encoder: wall beats head beats body beats apple.
  always_comb begin
    obj_code = 3'b000;
    if (bus.border)         obj_code = 3'b100;
    else if (bus.snakeHead) obj_code = 3'b001;
    else if (bus.snakeBody) obj_code = 3'b010;
    else if (bus.apple)     obj_code = 3'b011;
  end

  // FSM state register; reset parks the machine in RESET.
  always_ff @(posedge clk) begin
    if (!nrst) state <= S_RESET;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_SCAN;
      S_SCAN: begin
        if (need_draw)      state_nxt = S_WAIT;
        else if (last_cell) state_nxt = S_GAP;
      end
      S_WAIT: begin
        if (bus.cmd_done) state_nxt = last_cell ? S_GAP : S_SCAN;
      end
      S_GAP: begin
        if (gap_done) state_nxt = S_SCAN;
      end
      default: state_nxt = S_RESET;
    endcase
  end

  // FSM outputs: the request lives exactly as long as WAIT.
  always_comb begin
    bus.draw_req   = (state == S_WAIT);
    bus.frame_done = (state == S_GAP) && (gap_cnt == '0);
    bus.init_cycle = force_q;
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.obj_code  = obj_code;
  assign bus.draw_x    = dx_q;
  assign bus.draw_y    = dy_q;
  assign bus.draw_code = dcode_q;

  // Scan position: x fastest, wrapping to (0,0) after the last cell.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance) begin
      if (x_q == 4'(GRID_W - 1)) begin
        x_q <= '0;
        y_q <= last_cell ? 4'd0 : y_q + 4'd1;
      end else begin
        x_q <= x_q + 4'd1;
      end
    end
  end

  // Command latch: captured once on the mismatching SCAN cycle, frozen during WAIT.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      dx_q    <= '0;
      dy_q    <= '0;
      dcode_q <= '0;
    end else if ((state == S_SCAN) && need_draw) begin
      dx_q    <= x_q;
      dy_q    <= y_q;
      dcode_q <= obj_code;
    end
  end

  // Shadow map update on command completion; contents are rebuilt by the forced frame after reset.
  always_ff @(posedge clk) begin
    if (nrst && (state == S_WAIT) && bus.cmd_done) shadow[wr_idx] <= dcode_q;
  end

  // Forced-redraw control: GameOver edges are deferred to the next frame boundary.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      force_q   <= 1'b1;
      pending_q <= 1'b0;
      go_q      <= bus.GameOver;
    end else begin
      go_q <= bus.GameOver;
      if (enter_gap) begin
        force_q   <= pending_q;
        pending_q <= go_rise;
      end else if (go_rise) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Inter-frame gap counter.
  always_ff @(posedge clk) begin
    if (!nrst)                gap_cnt <= '0;
    else if (state == S_GAP)  gap_cnt <= gap_done ? '0 : gap_cnt + GW'(1);
    else                      gap_cnt <= '0;
  end

endmodule

// File: tb/tb_tile_draw_scheduler.sv
// Directed bench for tile_draw_scheduler: a playfield map answers lookups, a responder acks draws, a scoreboard checks them.
// Latency: responder raises cmd_done on the third cycle of each draw request.
// Backpressure: the responder can be disabled to hold the scheduler in WAIT.
module tb_tile_draw_scheduler;

  logic tb_clk = 1'b0;
  logic nrst;
  logic cmd_done;
  logic game_over;
  logic resp_en;

  always #5 tb_clk = ~tb_clk;

  tile_draw_scheduler_if bus();

  tile_draw_scheduler #(.GRID_W(16), .GRID_H(12), .FRAME_GAP(0)) dut (
    .clk (tb_clk),
    .nrst(nrst),
    .bus (bus)
  );

  // Playfield: flags {border, head, body, apple} and the hand-assigned code each cell must draw as.
  logic [3:0] cell_flags [12][16];
  logic [2:0] cell_code  [12][16];
  logic [3:0] cur_flags;

  assign cur_flags     = cell_flags[bus.y][bus.x];
  assign bus.border    = cur_flags[3];
  assign bus.snakeHead = cur_flags[2];
  assign bus.snakeBody = cur_flags[1];
  assign bus.apple     = cur_flags[0];
  assign bus.cmd_done  = cmd_done;
  assign bus.GameOver  = game_over;

  logic [10:0] sb [$];
  int vectors = 0;
  int fails   = 0;
  int draw_cnt = 0;
  int cyc = 0;

  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic set_cell(input int cx, input int cy, input logic [3:0] fl, input logic [2:0] code);
    cell_flags[cy][cx] = fl;
    cell_code[cy][cx]  = code;
  endtask

  task automatic push_full_frame();
    for (int yy = 0; yy < 12; yy++)
      for (int xx = 0; xx < 16; xx++)
        sb.push_back({4'(xx), 4'(yy), cell_code[yy][xx]});
  endtask

  task automatic push_cell(input int cx, input int cy);
    sb.push_back({4'(cx), 4'(cy), cell_code[cy][cx]});
  endtask

  task automatic wait_frame_done(input string name, output int at);
    at = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge tb_clk);
      if (bus.frame_done) begin
        at = cyc;
        return;
      end
    end
    fails++;
    vectors++;
    $display("FAIL %s: frame_done not seen within 2000 cycles", name);
  endtask

  task automatic wait_cell(input string name, input int cx, input int cy);
    for (int i = 0; i < 400; i++) begin
      @(negedge tb_clk);
      if (bus.x == 4'(cx) && bus.y == 4'(cy)) return;
    end
    fails++;
    vectors++;
    $display("FAIL %s: cell (%0d,%0d) not reached within 400 cycles", name, cx, cy);
  endtask

  // Command engine model: ack each request on its third cycle.
  initial begin
    int wait_cnt;
    cmd_done = 1'b0;
    wait_cnt = 0;
    forever begin
      @(negedge tb_clk);
      if (cmd_done) begin
        cmd_done = 1'b0;
        wait_cnt = 0;
      end else if (bus.draw_req && resp_en) begin
        wait_cnt++;
        if (wait_cnt == 3) cmd_done = 1'b1;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every new draw request is popped against the scoreboard.
  initial begin
    logic        prev_req;
    logic [10:0] exp_e;
    logic [10:0] got_e;
    prev_req = 1'b0;
    forever begin
      @(negedge tb_clk);
      if (bus.draw_req && !prev_req) begin
        draw_cnt++;
        vectors++;
        got_e = {bus.draw_x, bus.draw_y, bus.draw_code};
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_draw: got (%0d,%0d) code %b, required no draw",
                   bus.draw_x, bus.draw_y, bus.draw_code);
        end else begin
          exp_e = sb.pop_front();
          if (got_e != exp_e) begin
            fails++;
            $display("FAIL draw_cmd: got (%0d,%0d) code %b, required (%0d,%0d) code %b",
                     got_e[10:7], got_e[6:3], got_e[2:0], exp_e[10:7], exp_e[6:3], exp_e[2:0]);
          end
        end
      end
      prev_req = bus.draw_req;
    end
  end

  initial begin
    int t_prev, t_now, snap;
    nrst      = 1'b0;
    game_over = 1'b0;
    resp_en   = 1'b1;

    // Base map: wall ring, head (4,4), body (5,4), apple (6,4).
    for (int yy = 0; yy < 12; yy++)
      for (int xx = 0; xx < 16; xx++)
        if (xx == 0 || xx == 15 || yy == 0 || yy == 11) set_cell(xx, yy, 4'b1000, 3'b100);
        else                                            set_cell(xx, yy, 4'b0000, 3'b000);
    set_cell(4, 4, 4'b0100, 3'b001);
    set_cell(5, 4, 4'b0010, 3'b010);
    set_cell(6, 4, 4'b0001, 3'b011);

    // Reset held for two edges.
    @(negedge tb_clk);
    @(negedge tb_clk);
    check("rst_x", int'(bus.x), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_draw_req", int'(bus.draw_req), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_init_cycle", int'(bus.init_cycle), 1);

    push_full_frame();
    snap = draw_cnt;
    nrst = 1'b1;
    @(negedge tb_clk);
    check("first_scan_x", int'(bus.x), 0);
    check("first_scan_y", int'(bus.y), 0);
    check("first_scan_req", int'(bus.draw_req), 0);

    // Forced first frame.
    wait_frame_done("frame1", t_prev);
    check("frame1_draws", draw_cnt - snap, 192);
    check("frame1_init_fall", int'(bus.init_cycle), 0);
    check("frame1_sb_empty", sb.size(), 0);

    // Unchanged map: no draws, 193-cycle period.
    snap = draw_cnt;
    wait_frame_done("steady", t_now);
    check("steady_draws", draw_cnt - snap, 0);
    check("steady_period", t_now - t_prev, 193);

    // Snake moves one cell right.
    set_cell(4, 4, 4'b0000, 3'b000);
    set_cell(5, 4, 4'b0100, 3'b001);
    set_cell(6, 4, 4'b0010, 3'b010);
    push_cell(4, 4);
    push_cell(5, 4);
    push_cell(6, 4);
    snap = draw_cnt;
    wait_frame_done("move", t_now);
    check("move_draws", draw_cnt - snap, 3);
    check("move_sb_empty", sb.size(), 0);

    // Overlapping flags resolve by priority, matching what is already on screen.
    set_cell(0, 3, 4'b1100, 3'b100);
    set_cell(5, 4, 4'b0101, 3'b001);
    snap = draw_cnt;
    wait_cell("prio_wall", 0, 3);
    check("prio_wall_head", int'(bus.obj_code), 4);
    wait_cell("prio_head", 5, 4);
    check("prio_head_apple", int'(bus.obj_code), 1);
    wait_frame_done("prio", t_now);
    check("prio_draws", draw_cnt - snap, 0);

    // Reset while a command is outstanding.
    set_cell(8, 6, 4'b0001, 3'b011);
    push_cell(8, 6);
    resp_en = 1'b0;
    for (int i = 0; i < 400 && !bus.draw_req; i++) @(negedge tb_clk);
    check("wait_reached", int'(bus.draw_req), 1);
    nrst = 1'b0;
    @(negedge tb_clk);
    check("rst_wait_req_drop", int'(bus.draw_req), 0);
    check("rst_wait_init", int'(bus.init_cycle), 1);
    push_full_frame();
    nrst    = 1'b1;
    resp_en = 1'b1;
    snap    = draw_cnt;
    wait_frame_done("rst_frame", t_now);
    check("rst_frame_draws", draw_cnt - snap, 192);
    check("rst_frame_init_fall", int'(bus.init_cycle), 0);
    check("rst_frame_sb_empty", sb.size(), 0);

    // GameOver mid-frame: current frame finishes untouched, next frame is forced.
    snap = draw_cnt;
    repeat (60) @(negedge tb_clk);
    game_over = 1'b1;
    repeat (5) @(negedge tb_clk);
    check("go_no_interrupt", int'(bus.init_cycle), 0);
    wait_frame_done("go_frame", t_now);
    check("go_frame_draws", draw_cnt - snap, 0);
    check("go_init_rise", int'(bus.init_cycle), 1);
    push_full_frame();
    snap      = draw_cnt;
    game_over = 1'b0;
    wait_frame_done("go_redraw", t_now);
    check("go_redraw_draws", draw_cnt - snap, 192);
    check("go_redraw_init_fall", int'(bus.init_cycle), 0);
    check("go_redraw_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
